// File: rtl/fitness_population_scheduler_if.sv
// Evaluator-side handshake between the population scheduler (master) and
// the shared morphologic fitness evaluator (slave).
interface fitness_population_scheduler_if #(
    parameter int InstructionWidth = 64,
    parameter int ErrorWidth       = 5
);
    logic                        fit_start;
    logic [InstructionWidth-1:0] fit_individual;
    logic [ErrorWidth-1:0]       fit_error;
    logic                        fit_finish;
    logic                        fit_buzy;

    modport master (
        output fit_start,
        output fit_individual,
        input  fit_error,
        input  fit_finish,
        input  fit_buzy
    );

    modport slave (
        input  fit_start,
        input  fit_individual,
        output fit_error,
        output fit_finish,
        output fit_buzy
    );
endinterface

// File: rtl/fitness_population_scheduler.sv
// Runs one shared fitness evaluator over every individual of a latched
// population, streaming per-individual errors and tracking the best one.
module fitness_population_scheduler #(
    parameter int PopulationSize   = 8,
    parameter int IndexWidth       = $clog2(PopulationSize),
    parameter int InstructionWidth = 64,
    parameter int ErrorWidth       = 5,
    parameter int TimeoutCycles    = 1024,
    parameter int TimeoutWidth     = $clog2(TimeoutCycles + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [PopulationSize*InstructionWidth-1:0] population,
    output logic                                   busy,
    output logic                                   done,
    fitness_population_scheduler_if.master         fit,
    output logic                                   result_valid,
    output logic [IndexWidth-1:0]                  result_index,
    output logic [ErrorWidth-1:0]                  result_error,
    output logic [IndexWidth-1:0]                  best_index,
    output logic [ErrorWidth-1:0]                  best_error,
    output logic [IndexWidth:0]                    timeout_count
);

    localparam int CountWidth = IndexWidth + 1;
    localparam logic [IndexWidth-1:0]   LastIdx    = IndexWidth'(PopulationSize - 1);
    localparam logic [TimeoutWidth-1:0] TimerLast  = TimeoutWidth'(TimeoutCycles - 1);
    localparam logic [ErrorWidth-1:0]   ErrAllOnes = {ErrorWidth{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_RUN       = 3'd3,
        ST_RECORD    = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;
    logic [InstructionWidth-1:0] latched_r [PopulationSize];
    logic [IndexWidth-1:0]       idx_r;
    logic [IndexWidth-1:0]       idx_next_s;
    logic [TimeoutWidth-1:0]     timer_r;
    logic [ErrorWidth-1:0]       cap_r;
    logic [IndexWidth-1:0]       result_index_r;
    logic [IndexWidth-1:0]       best_index_r;
    logic [ErrorWidth-1:0]       best_error_r;
    logic [CountWidth-1:0]       timeout_count_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        fit_start_r;
    logic                        result_valid_r;
    logic [InstructionWidth-1:0] fit_individual_r;
    logic                        finish_hit_s;
    logic                        timeout_hit_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a finish in the same cycle as the timeout wins.
    always_comb begin
        state_next_s  = state_r;
        finish_hit_s  = 1'b0;
        timeout_hit_s = 1'b0;
        idx_next_s    = idx_r + IndexWidth'(1'b1);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_WAIT_IDLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!fit.fit_buzy) begin
                    state_next_s = ST_LAUNCH;
                end else begin
                    state_next_s = ST_WAIT_IDLE;
                end
            end
            ST_LAUNCH: state_next_s = ST_RUN;
            ST_RUN: begin
                if (fit.fit_finish) begin
                    finish_hit_s = 1'b1;
                    state_next_s = ST_RECORD;
                end else if (timer_r == TimerLast) begin
                    timeout_hit_s = 1'b1;
                    state_next_s  = ST_RECORD;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_RECORD: begin
                if (idx_r == LastIdx) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT_IDLE;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; pulse outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PopulationSize; k++) begin
                latched_r[k] <= '0;
            end
            idx_r            <= '0;
            timer_r          <= '0;
            cap_r            <= '0;
            result_index_r   <= '0;
            best_index_r     <= '0;
            best_error_r     <= ErrAllOnes;
            timeout_count_r  <= '0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            fit_start_r      <= 1'b0;
            result_valid_r   <= 1'b0;
            fit_individual_r <= '0;
        end else begin
            busy_r         <= (state_next_s != ST_IDLE);
            done_r         <= (state_next_s == ST_DONE);
            fit_start_r    <= (state_next_s == ST_LAUNCH);
            result_valid_r <= (state_next_s == ST_RECORD);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < PopulationSize; k++) begin
                            latched_r[k] <= population[k*InstructionWidth +: InstructionWidth];
                        end
                        fit_individual_r <= population[InstructionWidth-1:0];
                        idx_r            <= '0;
                        best_error_r     <= ErrAllOnes;
                        best_index_r     <= '0;
                        timeout_count_r  <= '0;
                    end
                end
                ST_LAUNCH: timer_r <= '0;
                ST_RUN: begin
                    timer_r <= timer_r + TimeoutWidth'(1'b1);
                    if (finish_hit_s) begin
                        cap_r          <= fit.fit_error;
                        result_index_r <= idx_r;
                    end else if (timeout_hit_s) begin
                        cap_r           <= ErrAllOnes;
                        result_index_r  <= idx_r;
                        timeout_count_r <= timeout_count_r + CountWidth'(1'b1);
                    end
                end
                ST_RECORD: begin
                    // Strict compare keeps the lower index on ties.
                    if (cap_r < best_error_r) begin
                        best_error_r <= cap_r;
                        best_index_r <= idx_r;
                    end
                    if (idx_r != LastIdx) begin
                        idx_r            <= idx_next_s;
                        fit_individual_r <= latched_r[idx_next_s];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy               = busy_r;
    assign done               = done_r;
    assign fit.fit_start      = fit_start_r;
    assign fit.fit_individual = fit_individual_r;
    assign result_valid       = result_valid_r;
    assign result_index       = result_index_r;
    assign result_error       = cap_r;
    assign best_index         = best_index_r;
    assign best_error         = best_error_r;
    assign timeout_count      = timeout_count_r;

endmodule

// File: tb/tb_fitness_population_scheduler.sv
// Directed bench: a behavioural evaluator derives each error from the low
// bits of the individual it was launched with; bit 15 set means it never finishes.
module tb_fitness_population_scheduler;

    localparam int PS  = 4;
    localparam int IW  = 16;
    localparam int EW  = 5;
    localparam int LAT = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic [PS*IW-1:0]  population;
    logic              busy;
    logic              done;
    logic              result_valid;
    logic [1:0]        result_index;
    logic [EW-1:0]     result_error;
    logic [1:0]        best_index;
    logic [EW-1:0]     best_error;
    logic [2:0]        timeout_count;
    logic              buzy_force;

    fitness_population_scheduler_if #(.InstructionWidth(IW), .ErrorWidth(EW)) bus ();

    fitness_population_scheduler #(
        .PopulationSize(PS),
        .InstructionWidth(IW),
        .ErrorWidth(EW),
        .TimeoutCycles(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .population(population),
        .busy(busy),
        .done(done),
        .fit(bus),
        .result_valid(result_valid),
        .result_index(result_index),
        .result_error(result_error),
        .best_index(best_index),
        .best_error(best_error),
        .timeout_count(timeout_count)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int fs_count = 0;
    int done_cnt = 0;
    int last_rv_cyc = 0;
    int done_cyc = 0;
    int res_idx[$];
    int res_err[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.fit_buzy = buzy_force;

    // Evaluator model, driven on the falling edge.
    logic [IW-1:0] cur;
    int            cnt = 0;
    bit            pend = 1'b0;
    always @(negedge clk) begin
        bus.fit_finish = 1'b0;
        bus.fit_error  = 5'd21;
        if (bus.fit_start === 1'b1) begin
            fs_count++;
            pend = 1'b1;
            cnt  = LAT;
            cur  = bus.fit_individual;
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend = 1'b0;
                if (!cur[15]) begin
                    bus.fit_finish = 1'b1;
                    bus.fit_error  = cur[4:0];
                end
            end
        end
    end

    // Result and done monitor.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            res_idx.push_back(int'(result_index));
            res_err.push_back(int'(result_error));
            last_rv_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [PS*IW-1:0] mk(input logic [IW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic pulse_start(input logic [PS*IW-1:0] pop);
        population = pop;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_gen(input string tag, input int e0, e1, e2, e3,
                             input int bi, be, tc);
        int exp_e[4];
        exp_e = '{e0, e1, e2, e3};
        check({tag, "_count"}, res_idx.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_idx"}, (k < res_idx.size()) ? res_idx[k] : -1, k);
            check({tag, "_err"}, (k < res_err.size()) ? res_err[k] : -1, exp_e[k]);
        end
        check({tag, "_best_index"}, best_index, bi);
        check({tag, "_best_error"}, best_error, be);
        check({tag, "_timeout_count"}, timeout_count, tc);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fit_start"}, bus.fit_start, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_fit_individual"}, bus.fit_individual, 0);
        check({tag, "_result_index"}, result_index, 0);
        check({tag, "_result_error"}, result_error, 0);
        check({tag, "_best_index"}, best_index, 0);
        check({tag, "_best_error"}, best_error, 31);
        check({tag, "_timeout_count"}, timeout_count, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int n;
        int dc;
        rst = 1'b1;
        start = 1'b0;
        population = '0;
        buzy_force = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic generation: errors 7,3,9,3.
        res_idx.delete(); res_err.delete(); fs_count = 0;
        pulse_start(mk(16'h0107, 16'h0203, 16'h0309, 16'h0403));
        wait_done(300);
        @(negedge clk);
        check_gen("basic", 7, 3, 9, 3, 1, 3, 0);
        check("basic_done_gap", done_cyc - last_rv_cyc, 1);
        check("basic_done_one_cycle", done, 0);
        check("basic_busy_after", busy, 0);
        check("basic_fit_starts", fs_count, 4);

        // Ties keep the lowest index.
        res_idx.delete(); res_err.delete();
        pulse_start(mk(16'h0502, 16'h0602, 16'h0702, 16'h0802));
        wait_done(300);
        @(negedge clk);
        check_gen("ties", 2, 2, 2, 2, 0, 2, 0);

        // Index 2 never finishes and must time out.
        res_idx.delete(); res_err.delete();
        pulse_start(mk(16'h0604, 16'h0704, 16'h8000, 16'h0804));
        wait_done(300);
        @(negedge clk);
        check_gen("timeout", 4, 4, 31, 4, 0, 4, 1);

        // Evaluator busy for 10 cycles after start.
        res_idx.delete(); res_err.delete(); fs_count = 0;
        buzy_force = 1'b1;
        pulse_start(mk(16'h0905, 16'h0A06, 16'h0B01, 16'h0C08));
        repeat (9) @(negedge clk);
        check("buzy_no_launch", fs_count, 0);
        check("buzy_busy", busy, 1);
        buzy_force = 1'b0;
        @(negedge clk);
        check("buzy_launch_after_drop", bus.fit_start, 1);
        @(negedge clk);
        check("buzy_launch_single", bus.fit_start, 0);
        wait_done(300);
        @(negedge clk);
        check_gen("buzy", 5, 6, 1, 8, 2, 1, 0);
        check("buzy_fit_starts", fs_count, 4);

        // start held high; population changed mid-run.
        res_idx.delete(); res_err.delete();
        population = mk(16'h0D0A, 16'h0E0C, 16'h0F0B, 16'h100E);
        start = 1'b1;
        repeat (4) @(negedge clk);
        population = mk(16'h1101, 16'h1201, 16'h1301, 16'h1401);
        wait_done(300);
        check_gen("held_gen1", 10, 12, 11, 14, 0, 10, 0);
        res_idx.delete(); res_err.delete();
        @(negedge clk);
        check("held_idle_gap", busy, 0);
        @(negedge clk);
        check("held_restart", busy, 1);
        start = 1'b0;
        wait_done(300);
        @(negedge clk);
        check_gen("held_gen2", 1, 1, 1, 1, 0, 1, 0);

        // Reset during RUN of index 1.
        res_idx.delete(); res_err.delete();
        pulse_start(mk(16'h1503, 16'h1603, 16'h1703, 16'h1803));
        seen = 0;
        n = 0;
        while (seen < 2 && n < 100) begin
            @(negedge clk);
            if (bus.fit_start === 1'b1) seen++;
            n++;
        end
        check("midrst_second_launch", seen, 2);
        @(negedge clk);
        dc = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_done", done_cnt, dc);
        check("midrst_idle", busy, 0);
        res_idx.delete(); res_err.delete(); fs_count = 0;
        pulse_start(mk(16'h1906, 16'h1A02, 16'h1B08, 16'h1C04));
        wait_done(300);
        @(negedge clk);
        check_gen("restart", 6, 2, 8, 4, 1, 2, 0);
        check("restart_fit_starts", fs_count, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
